// File: rtl/vme_cmd_seq.sv
// vme_cmd_seq: plays a loaded program of VME write/read/wait/end entries
// through the command decoder handshake and logs every completed command
// into a first-word-fall-through result FIFO.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   load_we/addr/op/cmd/data program loader (accepted in IDLE/DONE only)
//   go, loop_en, abort       playback control
//   vme_cmd_rd, vme_dat_wr   decoder ready / decoder response valid
//   vme_dat_reg_out          decoder response data
//   start, vme_cmd_reg,      one-cycle command strobe with command word and
//   vme_dat_reg_in           write data (idle values: MASK and 0)
//   res_valid/res_ready      result FIFO handshake
//   res_rd/res_cmd/res_data  head-of-FIFO result
//   busy, done, pc           playback status (expose the sequencer state)
//   err_timeout, err_ovf     sticky errors, cleared by go
//
// Result handshake: a result is transferred on a rising clk edge where
// res_valid and res_ready are both high; res_valid stays high with stable
// res_rd/res_cmd/res_data until that transfer happens.
module vme_cmd_seq #(
  parameter int          DAT_W     = 16,
  parameter int          DEPTH     = 64,
  parameter int          RES_DEPTH = 16,
  parameter logic [31:0] MASK      = 32'h00A80000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [1:0]               load_op,
  input  logic [15:0]              load_cmd,
  input  logic [DAT_W-1:0]         load_data,
  input  logic                     go,
  input  logic                     loop_en,
  input  logic                     abort,
  input  logic                     vme_cmd_rd,
  input  logic                     vme_dat_wr,
  input  logic [31:0]              vme_dat_reg_out,
  output logic                     start,
  output logic [31:0]              vme_cmd_reg,
  output logic [31:0]              vme_dat_reg_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_rd,
  output logic [15:0]              res_cmd,
  output logic [DAT_W-1:0]         res_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic                     err_ovf,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int CW = RW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 2 + 16 + DAT_W;
  localparam int FW = 1 + 16 + DAT_W;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_RESP, S_DELAY, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DAT_W-1:0]  dly_q, dly_d;
  logic              start_q, start_d;
  logic [31:0]       cmd_reg_q, cmd_reg_d;
  logic [31:0]       dat_in_q, dat_in_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_ovf_q, err_ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [RW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [EW-1:0]     cmd_mem [DEPTH];
  logic [FW-1:0]     res_mem [RES_DEPTH];
  logic [EW-1:0]     ent_q;

  logic              mem_we, adv, push, pop, full, do_push, ent_is_rd;
  logic [1:0]        ent_op;
  logic [15:0]       ent_cmd;
  logic [DAT_W-1:0]  ent_data;
  logic [31:0]       data_ext;
  logic [FW-1:0]     push_data;
  logic              unused_resp_bits;

  // Entry register always holds mem[pc]; pc only moves on FETCH/advance and
  // the memory is frozen while playing, so it stays valid through ISSUE and
  // WAIT_RESP.
  assign ent_op    = ent_q[EW-1 -: 2];
  assign ent_cmd   = ent_q[DAT_W +: 16];
  assign ent_data  = ent_q[DAT_W-1:0];
  assign ent_is_rd = (ent_op == OP_RD);
  assign mem_we    = load_we && (state_q == S_IDLE || state_q == S_DONE);
  assign unused_resp_bits = ^vme_dat_reg_out;

  always_comb begin
    data_ext = '0;
    data_ext[DAT_W-1:0] = ent_data;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tmo_d     = tmo_q;
    dly_d     = dly_q;
    start_d   = 1'b0;
    cmd_reg_d = MASK;
    dat_in_d  = '0;
    err_tmo_d = err_tmo_q;
    err_ovf_d = err_ovf_q;
    push      = 1'b0;
    adv       = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            pc_d      = '0;
            err_tmo_d = 1'b0;
            err_ovf_d = 1'b0;
            state_d   = S_FETCH;
          end
        end
        S_FETCH: begin
          if (ent_op == OP_WR || ent_op == OP_RD) begin
            state_d = S_ISSUE;
          end else if (ent_op == OP_WAIT) begin
            dly_d   = ent_data;
            state_d = S_DELAY;
          end else if (loop_en) begin
            pc_d    = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
        S_ISSUE: begin
          if (vme_cmd_rd) begin
            start_d   = 1'b1;
            cmd_reg_d = MASK | {16'h0000, ent_cmd} |
                        (ent_is_rd ? 32'h0200_0000 : 32'h0100_0000);
            dat_in_d  = data_ext;
            tmo_d     = '0;
            state_d   = S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (vme_dat_wr) begin
            push = 1'b1;
            adv  = 1'b1;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_tmo_d = 1'b1;
            adv       = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_DELAY: begin
          if (dly_q == '0) adv = 1'b1;
          else             dly_d = dly_q - DAT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase

      if (adv) begin
        if (pc_q == AW'(DEPTH - 1)) begin
          if (loop_en) begin
            pc_d    = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_FETCH;
        end
      end
    end

    // Result FIFO: a pop in the same cycle frees the slot for a push.
    push_data = {ent_is_rd, ent_cmd,
                 ent_is_rd ? vme_dat_reg_out[DAT_W-1:0] : ent_data};
    pop      = (cnt_q != '0) && res_ready;
    full     = (cnt_q == CW'(RES_DEPTH));
    do_push  = push && (!full || pop);
    if (push && !do_push) err_ovf_d = 1'b1;
    wr_ptr_d = do_push ? wr_ptr_q + RW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + RW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && pop) cnt_d = cnt_q - CW'(1);

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      tmo_q     <= '0;
      dly_q     <= '0;
      start_q   <= 1'b0;
      cmd_reg_q <= MASK;
      dat_in_q  <= '0;
      err_tmo_q <= 1'b0;
      err_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tmo_q     <= tmo_d;
      dly_q     <= dly_d;
      start_q   <= start_d;
      cmd_reg_q <= cmd_reg_d;
      dat_in_q  <= dat_in_d;
      err_tmo_q <= err_tmo_d;
      err_ovf_q <= err_ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by state and count.
  always_ff @(posedge clk) begin
    if (mem_we) cmd_mem[load_addr] <= {load_op, load_cmd, load_data};
    ent_q <= cmd_mem[pc_d];
    if (do_push) res_mem[wr_ptr_q] <= push_data;
  end

  assign start          = start_q;
  assign vme_cmd_reg    = cmd_reg_q;
  assign vme_dat_reg_in = dat_in_q;
  assign res_valid      = (cnt_q != '0);
  assign {res_rd, res_cmd, res_data} = res_mem[rd_ptr_q];
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_tmo_q;
  assign err_ovf        = err_ovf_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_vme_cmd_seq.sv
module tb_vme_cmd_seq;

  localparam logic [31:0] MASK = 32'h00A80000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_we, go, loop_en, abort, vme_cmd_rd, vme_dat_wr, res_ready;
  logic [2:0]  load_addr;
  logic [1:0]  load_op;
  logic [15:0] load_cmd, load_data;
  logic [31:0] vme_dat_reg_out;
  logic        start, res_valid, res_rd, busy, done, err_timeout, err_ovf;
  logic [31:0] vme_cmd_reg, vme_dat_reg_in;
  logic [15:0] res_cmd, res_data;
  logic [2:0]  pc;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  // decoder model / start monitor state
  bit          resp_en = 1'b0;
  logic [15:0] resp_data = 16'h0;
  bit          pend = 1'b0;
  bit          prev_start = 1'b0;
  int          n_double = 0;
  int          start_cyc_q[$];
  logic [31:0] cmd_log[$];
  logic [31:0] dat_log[$];

  // scoreboard: {rd, cmd, data}
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  vme_cmd_seq #(.DAT_W(16), .DEPTH(8), .RES_DEPTH(2), .MASK(MASK), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_we(load_we), .load_addr(load_addr),
    .load_op(load_op), .load_cmd(load_cmd), .load_data(load_data), .go(go),
    .loop_en(loop_en), .abort(abort), .vme_cmd_rd(vme_cmd_rd),
    .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out), .start(start),
    .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
    .res_cmd(res_cmd), .res_data(res_data), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_ovf(err_ovf), .pc(pc)
  );

  // ---------------- clock / cycle counter ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Decoder: answers one cycle after the start strobe when resp_en is set.
  initial begin
    vme_dat_wr = 1'b0;
    vme_dat_reg_out = 32'h0;
    forever begin
      @(posedge clk); #1;
      vme_dat_wr = 1'b0;
      if (pend) begin
        vme_dat_wr = 1'b1;
        vme_dat_reg_out = {16'hFFFF, resp_data};
        pend = 1'b0;
      end
      if (start) begin
        if (prev_start) n_double++;
        start_cyc_q.push_back(cyc_cnt);
        cmd_log.push_back(vme_cmd_reg);
        dat_log.push_back(vme_dat_reg_in);
        if (resp_en) pend = 1'b1;
      end
      prev_start = start;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_entry(input int addr, input logic [1:0] op,
                            input logic [15:0] cmd, input logic [15:0] data);
    step();
    load_we = 1'b1; load_addr = addr[2:0]; load_op = op;
    load_cmd = cmd; load_data = data;
    step();
    load_we = 1'b0;
  endtask

  task automatic clear_logs();
    start_cyc_q.delete(); cmd_log.delete(); dat_log.delete();
    exp_q.delete(); got_q.delete();
  endtask

  // Pulses go; returns the cycle in which go was high. Ends one cycle later.
  task automatic do_go(output int go_cyc);
    step();
    go = 1'b1; go_cyc = cyc_cnt;
    step();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (start) begin ok = 1'b1; break; end
    end
  endtask

  // Pops up to n results into got_q (no checking here).
  task automatic collect_results(input int n);
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 30 && !res_valid; w++) step();
      if (!res_valid) break;
      got_q.push_back({res_rd, res_cmd, res_data});
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b expected 0", start); end
    checks++; if (vme_cmd_reg !== MASK) begin errors++; $display("FAIL reset_cmd_reg: got %08h expected %08h", vme_cmd_reg, MASK); end
    checks++; if (vme_dat_reg_in !== 32'h0) begin errors++; $display("FAIL reset_dat_in: got %08h expected 0", vme_dat_reg_in); end
    checks++; if ({res_valid, busy, done, err_timeout, err_ovf} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %05b expected 00000", {res_valid, busy, done, err_timeout, err_ovf}); end
    checks++; if (pc !== 3'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    bit ok; int g;
    resp_en = 1'b1; resp_data = 16'h1234;
    load_entry(0, 2'b00, 16'h4000, 16'h00FF);
    load_entry(1, 2'b01, 16'h4100, 16'h0000);
    load_entry(2, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_done: got done=%0b expected 1", done); end
    checks++; if (start_cyc_q.size() != 2) begin errors++; $display("FAIL wr_start_count: got %0d expected 2", start_cyc_q.size()); end
    else begin
      checks++; if (start_cyc_q[0] - g != 3) begin errors++; $display("FAIL wr_go_latency: got %0d expected 3", start_cyc_q[0] - g); end
      checks++; if (start_cyc_q[1] - start_cyc_q[0] != 4) begin errors++; $display("FAIL wr_b2b_spacing: got %0d expected 4", start_cyc_q[1] - start_cyc_q[0]); end
      checks++; if (cmd_log[0] !== 32'h01A84000) begin errors++; $display("FAIL wr_cmd0: got %08h expected 01a84000", cmd_log[0]); end
      checks++; if (dat_log[0] !== 32'h000000FF) begin errors++; $display("FAIL wr_dat0: got %08h expected 000000ff", dat_log[0]); end
      checks++; if (cmd_log[1] !== 32'h02A84100) begin errors++; $display("FAIL wr_cmd1: got %08h expected 02a84100", cmd_log[1]); end
    end
    checks++; if (pc !== 3'd2 || busy !== 1'b0) begin errors++; $display("FAIL wr_end_state: got pc=%0d busy=%0b expected pc=2 busy=0", pc, busy); end
    checks++; if (vme_cmd_reg !== MASK) begin errors++; $display("FAIL wr_idle_cmd: got %08h expected %08h", vme_cmd_reg, MASK); end
    exp_q.push_back({1'b0, 16'h4000, 16'h00FF});
    exp_q.push_back({1'b1, 16'h4100, 16'h1234});
    collect_results(2);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL wr_result_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr_result%0d: got %09h expected %09h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_cmd_rd_stall();
    bit ok; int g; int x;
    resp_en = 1'b1; vme_cmd_rd = 1'b0;
    load_entry(0, 2'b00, 16'h4500, 16'hA5A5);
    load_entry(1, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    repeat (8) step();
    checks++; if (start_cyc_q.size() != 0 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold: got starts=%0d busy=%0b expected 0/1", start_cyc_q.size(), busy); end
    vme_cmd_rd = 1'b1; x = cyc_cnt;
    wait_done(50, ok);
    checks++; if (start_cyc_q.size() != 1 || start_cyc_q[0] != x + 1) begin errors++; $display("FAIL stall_release: got starts=%0d first-offset=%0d expected 1/1", start_cyc_q.size(), (start_cyc_q.size() > 0) ? start_cyc_q[0] - x : -1); end
    collect_results(1);
    checks++; if (got_q.size() != 1 || got_q[0] !== {1'b0, 16'h4500, 16'hA5A5}) begin errors++; $display("FAIL stall_result: got n=%0d val=%09h expected 1/04500a5a5", got_q.size(), (got_q.size() > 0) ? got_q[0] : 33'h0); end
  endtask

  task automatic test_wait_delay();
    bit ok; int g;
    resp_en = 1'b1;
    load_entry(0, 2'b00, 16'h4000, 16'h0001);
    load_entry(1, 2'b10, 16'h0000, 16'd20);
    load_entry(2, 2'b00, 16'h4002, 16'h0002);
    load_entry(3, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    wait_done(200, ok);
    checks++; if (!ok || start_cyc_q.size() != 2) begin errors++; $display("FAIL wait20_run: got done=%0b starts=%0d expected 1/2", done, start_cyc_q.size()); end
    else begin
      checks++; if (start_cyc_q[1] - start_cyc_q[0] != 26) begin errors++; $display("FAIL wait20_spacing: got %0d expected 26", start_cyc_q[1] - start_cyc_q[0]); end
    end
    exp_q.push_back({1'b0, 16'h4000, 16'h0001});
    exp_q.push_back({1'b0, 16'h4002, 16'h0002});
    collect_results(2);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL wait20_results: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wait20_result%0d: got %09h expected %09h", i, got_q[i], exp_q[i]); end
    end
    // zero-count wait costs a single DELAY cycle
    load_entry(1, 2'b10, 16'h0000, 16'd0);
    clear_logs();
    do_go(g);
    wait_done(100, ok);
    checks++; if (start_cyc_q.size() != 2) begin errors++; $display("FAIL wait0_starts: got %0d expected 2", start_cyc_q.size()); end
    else begin
      checks++; if (start_cyc_q[1] - start_cyc_q[0] != 6) begin errors++; $display("FAIL wait0_spacing: got %0d expected 6", start_cyc_q[1] - start_cyc_q[0]); end
    end
    collect_results(2);
    // program without END finishes after the last entry
    for (int a = 0; a < 8; a++) load_entry(a, 2'b10, 16'h0000, 16'd0);
    clear_logs();
    do_go(g);
    wait_done(100, ok);
    checks++; if (!ok || pc !== 3'd7 || start_cyc_q.size() != 0) begin errors++; $display("FAIL last_entry: got done=%0b pc=%0d starts=%0d expected 1/7/0", done, pc, start_cyc_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok; int g; int c;
    resp_en = 1'b0;
    load_entry(0, 2'b01, 16'h4200, 16'h0000);
    load_entry(1, 2'b00, 16'h4300, 16'h0055);
    load_entry(2, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    wait_start(20, ok);
    c = cyc_cnt;
    checks++; if (!ok) begin errors++; $display("FAIL tmo_first_start: got none expected start"); end
    repeat (15) step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %0b at +15 expected 0", err_timeout); end
    step();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %0b at +16 expected 1", err_timeout); end
    wait_done(100, ok);
    checks++; if (!ok || start_cyc_q.size() != 2) begin errors++; $display("FAIL tmo_run: got done=%0b starts=%0d expected 1/2", done, start_cyc_q.size()); end
    else begin
      checks++; if (start_cyc_q[1] - c != 18 || cmd_log[1] !== 32'h01A84300) begin errors++; $display("FAIL tmo_next_issue: got offset=%0d cmd=%08h expected 18/01a84300", start_cyc_q[1] - c, cmd_log[1]); end
    end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL tmo_no_result: got res_valid=%0b expected 0", res_valid); end
  endtask

  task automatic test_overflow();
    bit ok; int g;
    resp_en = 1'b1; resp_data = 16'hBEEF;
    load_entry(0, 2'b01, 16'h5000, 16'h0000);
    load_entry(1, 2'b01, 16'h5001, 16'h0000);
    load_entry(2, 2'b01, 16'h5002, 16'h0000);
    load_entry(3, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    wait_done(200, ok);
    checks++; if (!ok || start_cyc_q.size() != 3) begin errors++; $display("FAIL ovf_run: got done=%0b starts=%0d expected 1/3", done, start_cyc_q.size()); end
    checks++; if (err_ovf !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL ovf_flags: got ovf=%0b tmo=%0b expected 1/0", err_ovf, err_timeout); end
    exp_q.push_back({1'b1, 16'h5000, 16'hBEEF});
    exp_q.push_back({1'b1, 16'h5001, 16'hBEEF});
    collect_results(3);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL ovf_held: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_result%0d: got %09h expected %09h", i, got_q[i], exp_q[i]); end
    end
    clear_logs();
    do_go(g);
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_by_go: got %0b expected 0", err_ovf); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_abort_idle: got busy=%0b expected 0", busy); end
    repeat (8) step();
    checks++; if (start_cyc_q.size() != 0) begin errors++; $display("FAIL ovf_abort_nostart: got %0d expected 0", start_cyc_q.size()); end
  endtask

  task automatic test_push_pop_full();
    bit ok; int g; int n;
    resp_en = 1'b1; resp_data = 16'hC0DE;
    load_entry(0, 2'b01, 16'h6000, 16'h0000);
    load_entry(1, 2'b01, 16'h6001, 16'h0000);
    load_entry(2, 2'b01, 16'h6002, 16'h0000);
    clear_logs();
    do_go(g);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      step();
      if (start) n++;
    end
    step();
    checks++; if (res_valid !== 1'b1 || res_cmd !== 16'h6000) begin errors++; $display("FAIL full_head: got valid=%0b cmd=%04h expected 1/6000", res_valid, res_cmd); end
    res_ready = 1'b1;   // pop in the same cycle as the third push
    step();
    res_ready = 1'b0;
    wait_done(50, ok);
    checks++; if (!ok || err_ovf !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got done=%0b ovf=%0b expected 1/0", done, err_ovf); end
    exp_q.push_back({1'b1, 16'h6001, 16'hC0DE});
    exp_q.push_back({1'b1, 16'h6002, 16'hC0DE});
    collect_results(3);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL full_remaining: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_result%0d: got %09h expected %09h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_loop_abort();
    int g; int n; int pops;
    resp_en = 1'b1; resp_data = 16'h0A0A; loop_en = 1'b1;
    load_entry(0, 2'b00, 16'h7000, 16'h0011);
    load_entry(1, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    res_ready = 1'b1;
    do_go(g);
    n = 0; pops = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      step();
      if (res_valid && res_ready) pops++;
      if (start) begin
        n++;
        if (n == 5) abort = 1'b1;
      end
    end
    step();
    abort = 1'b0;
    if (res_valid && res_ready) pops++;
    for (int i = 0; i < 15; i++) begin
      step();
      if (res_valid && res_ready) pops++;
    end
    res_ready = 1'b0; loop_en = 1'b0;
    checks++; if (start_cyc_q.size() != 5) begin errors++; $display("FAIL loop_pulses: got %0d expected 5", start_cyc_q.size()); end
    else begin
      checks++; if (start_cyc_q[4] - start_cyc_q[3] != 5 || cmd_log[4] !== 32'h01A87000) begin errors++; $display("FAIL loop_spacing: got %0d cmd=%08h expected 5/01a87000", start_cyc_q[4] - start_cyc_q[3], cmd_log[4]); end
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL loop_abort_idle: got busy=%0b done=%0b expected 0/0", busy, done); end
    checks++; if (pops != 4 || res_valid !== 1'b0) begin errors++; $display("FAIL loop_results: got pops=%0d valid=%0b expected 4/0", pops, res_valid); end
  endtask

  task automatic test_async_reset();
    bit ok; int g;
    resp_en = 1'b0;
    load_entry(0, 2'b01, 16'h4400, 16'h5A5A);
    load_entry(1, 2'b11, 16'h0000, 16'h0000);
    clear_logs();
    do_go(g);
    wait_start(20, ok);
    checks++; if (!ok || vme_dat_reg_in !== 32'h00005A5A) begin errors++; $display("FAIL arst_pre: got start=%0b dat=%08h expected 1/00005a5a", start, vme_dat_reg_in); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (start !== 1'b0 || vme_cmd_reg !== MASK || vme_dat_reg_in !== 32'h0) begin errors++; $display("FAIL arst_outputs: got start=%0b cmd=%08h dat=%08h expected 0/%08h/0", start, vme_cmd_reg, vme_dat_reg_in, MASK); end
    checks++; if (busy !== 1'b0 || pc !== 3'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL arst_state: got busy=%0b pc=%0d valid=%0b expected 0/0/0", busy, pc, res_valid); end
    step();
    rst_n = 1'b1;
    repeat (20) step();
    checks++; if (start_cyc_q.size() != 1 || err_timeout !== 1'b0) begin errors++; $display("FAIL arst_after: got starts=%0d tmo=%0b expected 1/0", start_cyc_q.size(), err_timeout); end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    load_we = 1'b0; load_addr = '0; load_op = '0; load_cmd = '0; load_data = '0;
    go = 1'b0; loop_en = 1'b0; abort = 1'b0; vme_cmd_rd = 1'b1; res_ready = 1'b0;
    test_reset();
    test_write_read();
    test_cmd_rd_stall();
    test_wait_delay();
    test_timeout();
    test_overflow();
    test_push_pop_full();
    test_loop_abort();
    test_async_reset();
    checks++; if (n_double != 0) begin errors++; $display("FAIL start_double: got %0d consecutive-start cycles expected 0", n_double); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
